// File: rtl/fp_wb_pkg.sv
// Shared types for the FP register-file writeback path: request record and source ids.
package fp_wb_pkg;

  localparam int FP_NREGS  = 32;
  localparam int FP_ADDR_W = 5;

  typedef struct packed {
    logic [FP_ADDR_W-1:0] rd;
    logic [31:0]          data;
  } wb_req_t;

  typedef enum logic {
    SRC_FPU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/fp_wb_fifo.sv
// Small synchronous FIFO of writeback requests; one instance buffers each producer.
module fp_wb_fifo
  import fp_wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  wb_req_t          data_i,
  input  logic             pop_i,
  output wb_req_t          head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // A full FIFO refuses a push even while it pops: no same-cycle pass-through.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is not reset; an entry is only ever read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP writeback arbiter: buffers FPU and FP-load results, round-robins them onto one
// registered register-file write. Define FP_WB_SCOREBOARD_EN to add the busy scoreboard.
module fp_wb_arbiter
  import fp_wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fpu_valid_i,
  output logic                fpu_ready_o,
  input  logic [ADDR_W-1:0]   fpu_rd_i,
  input  logic [DATA_W-1:0]   fpu_data_i,
  input  logic                lsu_valid_i,
  output logic                lsu_ready_o,
  input  logic [ADDR_W-1:0]   lsu_rd_i,
  input  logic [DATA_W-1:0]   lsu_data_i,
`ifdef FP_WB_SCOREBOARD_EN
  input  logic                issue_valid_i,
  input  logic [ADDR_W-1:0]   issue_rd_i,
  output logic [FP_NREGS-1:0] busy_o,
`endif
  output logic                fregwrite_o,
  output logic [ADDR_W-1:0]   frd_o,
  output logic [DATA_W-1:0]   wb_data_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_req_t          fpu_req, lsu_req, fpu_head, lsu_head, win_req;
  logic             fpu_full, lsu_full, fpu_empty, lsu_empty;
  logic [CNT_W-1:0] fpu_count, lsu_count;
  logic             fpu_grant, lsu_grant;
  src_e             last_grant_q;

  // The request record fixes rd/data widths, so ADDR_W/DATA_W must stay at their defaults.
  assign fpu_req = '{rd: fpu_rd_i, data: fpu_data_i};
  assign lsu_req = '{rd: lsu_rd_i, data: lsu_data_i};

  assign fpu_ready_o = (fpu_count != CNT_W'(FIFO_DEPTH));
  assign lsu_ready_o = (lsu_count != CNT_W'(FIFO_DEPTH));

  fp_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fpu_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fpu_valid_i & ~fpu_full),
    .data_i  (fpu_req),
    .pop_i   (fpu_grant),
    .head_o  (fpu_head),
    .full_o  (fpu_full),
    .empty_o (fpu_empty),
    .count_o (fpu_count)
  );

  fp_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (lsu_valid_i & ~lsu_full),
    .data_i  (lsu_req),
    .pop_i   (lsu_grant),
    .head_o  (lsu_head),
    .full_o  (lsu_full),
    .empty_o (lsu_empty),
    .count_o (lsu_count)
  );

  // Round robin: on contention the source that did not win last time goes first.
  assign fpu_grant = ~fpu_empty & (lsu_empty | (last_grant_q == SRC_LSU));
  assign lsu_grant = ~lsu_empty & ~fpu_grant;
  assign win_req   = fpu_grant ? fpu_head : lsu_head;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= SRC_LSU;
      fregwrite_o  <= 1'b0;
      frd_o        <= '0;
      wb_data_o    <= '0;
    end else begin
      fregwrite_o <= fpu_grant | lsu_grant;
      if (fpu_grant | lsu_grant) begin
        last_grant_q <= fpu_grant ? SRC_FPU : SRC_LSU;
        frd_o        <= win_req.rd;
        wb_data_o    <= win_req.data;
      end
    end
  end

`ifdef FP_WB_SCOREBOARD_EN
  logic [FP_NREGS-1:0] busy_d;

  // NOTE: combinational logic uses blocking (=) with a default first, so no latch is
  // inferred; the set is written after the clear so a same-index set wins.
  always_comb begin
    busy_d = busy_o;
    if (fregwrite_o)   busy_d[frd_o]      = 1'b0;
    if (issue_valid_i) busy_d[issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_o <= '0;
    else         busy_o <= busy_d;
  end
`endif

endmodule
